fifo_to_mem_window: RTL and testbench

Next-generation FIFO-to-memory write engine for the pcap replay micro-engine. It drains a first-word-fall-through packet FIFO into the QDR write port at one memory write per clock, within a software-programmable address window. The window either wraps (continuous capture) or stops when full (one-shot load with a done flag). A write counter and wrap counter are exported for the register block.

---
 rtl/fifo_to_mem_window.sv | 140 ++++++++++++++
 tb/tb_fifo_to_mem_window.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_to_mem_window.sv
// FWFT FIFO to QDR write-port drain engine with a programmable address window.
// Wraps for continuous capture or stops at the window end with a done flag.
module fifo_to_mem_window #(
  parameter int FIFO_DATA_WIDTH = 72,
  parameter int MEM_ADDR_WIDTH  = 19,
  parameter int MEM_DATA_WIDTH  = 36,
  parameter int MEM_BW_WIDTH    = 4,
  parameter int COUNT_WIDTH     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sw_rst,
  input  logic                       cal_done,
  input  logic                       cfg_enable,
  input  logic                       cfg_wrap,
  input  logic [MEM_ADDR_WIDTH-1:0]  cfg_addr_low,
  input  logic [MEM_ADDR_WIDTH-1:0]  cfg_addr_high,
  input  logic [FIFO_DATA_WIDTH-1:0] fifo_data,
  input  logic                       fifo_empty,
  output logic                       fifo_rd_en,
  input  logic                       mem_wr_full,
  output logic                       mem_ad_w_n,
  output logic                       mem_d_w_n,
  output logic [MEM_ADDR_WIDTH-1:0]  mem_ad_wr,
  output logic [MEM_DATA_WIDTH-1:0]  mem_dwl,
  output logic [MEM_DATA_WIDTH-1:0]  mem_dwh,
  output logic [MEM_BW_WIDTH-1:0]    mem_bwl_n,
  output logic [MEM_BW_WIDTH-1:0]    mem_bwh_n,
  output logic                       busy,
  output logic                       done,
  output logic                       cfg_err,
  output logic [COUNT_WIDTH-1:0]     wr_count,
  output logic [COUNT_WIDTH-1:0]     wrap_count
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e                    state_q;
  logic [MEM_ADDR_WIDTH-1:0] lo_q;
  logic [MEM_ADDR_WIDTH-1:0] hi_q;
  logic [MEM_ADDR_WIDTH-1:0] next_q;
  logic                      wrap_q;
  logic                      stb_n_q;
  logic [MEM_ADDR_WIDTH-1:0] addr_q;
  logic [MEM_DATA_WIDTH-1:0] dwl_q;
  logic [MEM_DATA_WIDTH-1:0] dwh_q;
  logic                      cfg_err_q;
  logic [COUNT_WIDTH-1:0]    wr_cnt_q;
  logic [COUNT_WIDTH-1:0]    wrap_cnt_q;
  logic                      issue;
  logic                      cfg_bad;

  // sw_rst wins over a same-cycle issue, so it must also block the pop
  assign issue = (state_q == RUN) & ~fifo_empty & ~mem_wr_full
               & cal_done & cfg_enable & ~sw_rst;
  assign cfg_bad = cfg_addr_high < cfg_addr_low;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      lo_q       <= '0;
      hi_q       <= '0;
      next_q     <= '0;
      wrap_q     <= 1'b0;
      stb_n_q    <= 1'b1;
      addr_q     <= '0;
      dwl_q      <= '0;
      dwh_q      <= '0;
      cfg_err_q  <= 1'b0;
      wr_cnt_q   <= '0;
      wrap_cnt_q <= '0;
    end else if (sw_rst) begin
      state_q    <= IDLE;
      stb_n_q    <= 1'b1;
      addr_q     <= '0;
      dwl_q      <= '0;
      dwh_q      <= '0;
      cfg_err_q  <= 1'b0;
      wr_cnt_q   <= '0;
      wrap_cnt_q <= '0;
    end else begin
      stb_n_q   <= ~issue;
      cfg_err_q <= (state_q == IDLE) & cfg_enable & cfg_bad;
      unique case (state_q)
        IDLE: begin
          if (cfg_enable && cal_done && !cfg_bad) begin
            state_q <= RUN;
            lo_q    <= cfg_addr_low;
            hi_q    <= cfg_addr_high;
            next_q  <= cfg_addr_low;
            wrap_q  <= cfg_wrap;
          end
        end
        RUN: begin
          if (!cfg_enable) begin
            state_q <= IDLE;
          end else if (issue) begin
            addr_q   <= next_q;
            dwl_q    <= fifo_data[MEM_DATA_WIDTH-1:0];
            dwh_q    <= fifo_data[2*MEM_DATA_WIDTH-1:MEM_DATA_WIDTH];
            wr_cnt_q <= wr_cnt_q + COUNT_WIDTH'(1);
            if (next_q == hi_q) begin
              if (wrap_q) begin
                next_q     <= lo_q;
                wrap_cnt_q <= wrap_cnt_q + COUNT_WIDTH'(1);
              end else begin
                state_q <= DONE;
              end
            end else begin
              next_q <= next_q + MEM_ADDR_WIDTH'(1);
            end
          end
        end
        DONE: begin
          if (!cfg_enable) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_rd_en = issue;
  assign mem_ad_w_n = stb_n_q;
  assign mem_d_w_n  = stb_n_q;
  assign mem_ad_wr  = addr_q;
  assign mem_dwl    = dwl_q;
  assign mem_dwh    = dwh_q;
  assign mem_bwl_n  = '0;
  assign mem_bwh_n  = '0;
  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign cfg_err    = cfg_err_q;
  assign wr_count   = wr_cnt_q;
  assign wrap_count = wrap_cnt_q;

endmodule

// File: tb/tb_fifo_to_mem_window.sv
// Directed bench for fifo_to_mem_window with a queue-backed FWFT FIFO model.
// Writes seen on the memory port are logged and compared to hand-built lists.
module tb_fifo_to_mem_window;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sw_rst = 1'b0;
  logic        cal_done = 1'b1;
  logic        cfg_enable = 1'b0;
  logic        cfg_wrap = 1'b0;
  logic [18:0] cfg_addr_low = '0;
  logic [18:0] cfg_addr_high = '0;
  logic [71:0] fifo_data = '0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en;
  logic        mem_wr_full = 1'b0;
  logic        mem_ad_w_n;
  logic        mem_d_w_n;
  logic [18:0] mem_ad_wr;
  logic [35:0] mem_dwl;
  logic [35:0] mem_dwh;
  logic [3:0]  mem_bwl_n;
  logic [3:0]  mem_bwh_n;
  logic        busy;
  logic        done;
  logic        cfg_err;
  logic [31:0] wr_count;
  logic [31:0] wrap_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [71:0] fq[$];
  logic [18:0] la[$];
  logic [71:0] ld[$];
  logic        ldn[$];
  logic        lds[$];
  int          lt[$];

  fifo_to_mem_window dut (
    .clk(clk), .rst(rst), .sw_rst(sw_rst), .cal_done(cal_done),
    .cfg_enable(cfg_enable), .cfg_wrap(cfg_wrap),
    .cfg_addr_low(cfg_addr_low), .cfg_addr_high(cfg_addr_high),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .mem_wr_full(mem_wr_full),
    .mem_ad_w_n(mem_ad_w_n), .mem_d_w_n(mem_d_w_n),
    .mem_ad_wr(mem_ad_wr), .mem_dwl(mem_dwl), .mem_dwh(mem_dwh),
    .mem_bwl_n(mem_bwl_n), .mem_bwh_n(mem_bwh_n),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .wr_count(wr_count), .wrap_count(wrap_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] got,
                     input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] word(input int i);
    return {36'hA_0000_0000 + 36'(i), 36'h5_0000_0000 + 36'(i)};
  endfunction

  task automatic fifo_upd();
    fifo_empty = (fq.size() == 0);
    fifo_data  = fifo_empty ? 72'h0 : fq[0];
  endtask

  task automatic push(input int base, input int n);
    for (int i = 0; i < n; i++) fq.push_back(word(base + i));
    fifo_upd();
  endtask

  task automatic clr_log();
    la.delete(); ld.delete(); ldn.delete(); lds.delete(); lt.delete();
  endtask

  task automatic tick();
    logic p;
    #1;
    p = fifo_rd_en;
    @(posedge clk);
    #1;
    cyc++;
    if (p) void'(fq.pop_front());
    fifo_upd();
    if (!mem_ad_w_n) begin
      la.push_back(mem_ad_wr);
      ld.push_back({mem_dwh, mem_dwl});
      ldn.push_back(done);
      lds.push_back(mem_d_w_n);
      lt.push_back(cyc);
    end
  endtask

  task automatic start(input logic [18:0] lo, input logic [18:0] hi,
                       input logic wr, input int base, input int n);
    cfg_enable = 1'b0;
    tick();
    fq.delete();
    cfg_addr_low  = lo;
    cfg_addr_high = hi;
    cfg_wrap      = wr;
    push(base, n);
    cfg_enable = 1'b1;
    tick();
    clr_log();
  endtask

  initial begin
    int bad;
    logic [18:0] exp2 [7];
    exp2 = '{0, 1, 2, 0, 1, 2, 0};

    #1 rst = 1'b1;
    #2;
    chk("rst_stb", mem_ad_w_n, 1);
    chk("rst_addr", mem_ad_wr, 0);
    chk("rst_data", {mem_dwh, mem_dwl}, 0);
    chk("rst_flags", {busy, done, cfg_err, fifo_rd_en}, 0);
    chk("rst_cnt", {wr_count, wrap_count}, 0);
    chk("bw_n", {mem_bwh_n, mem_bwl_n}, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // one-shot window 0x10..0x13 with six queued words
    start(19'h10, 19'h13, 1'b0, 0, 6);
    repeat (8) tick();
    chk("os_n", la.size(), 4);
    for (int k = 0; k < 4 && k < la.size(); k++) begin
      chk($sformatf("os_addr%0d", k), la[k], 19'h10 + 19'(k));
      chk($sformatf("os_data%0d", k), ld[k], word(k));
      chk($sformatf("os_dstb%0d", k), lds[k], 0);
    end
    if (la.size() == 4) begin
      chk("os_b2b", lt[3] - lt[0], 3);
      chk("os_done_early", ldn[2], 0);
      chk("os_done_last", ldn[3], 1);
    end
    chk("os_done", done, 1);
    chk("os_busy", busy, 0);
    chk("os_left", fq.size(), 2);
    chk("os_wr", wr_count, 4);

    // soft reset from DONE clears the counters
    sw_rst = 1'b1;
    cfg_enable = 1'b0;
    tick();
    sw_rst = 1'b0;
    chk("swr_cnt", {wr_count, wrap_count}, 0);
    chk("swr_done", done, 0);

    // wrapping window 0..2 with seven words
    start(19'd0, 19'd2, 1'b1, 100, 7);
    repeat (10) tick();
    chk("wr_n", la.size(), 7);
    for (int k = 0; k < 7 && k < la.size(); k++) begin
      chk($sformatf("wr_addr%0d", k), la[k], exp2[k]);
      chk($sformatf("wr_data%0d", k), ld[k], word(100 + k));
    end
    chk("wr_wrapc", wrap_count, 2);
    chk("wr_wrc", wr_count, 7);
    chk("wr_busy", busy, 1);

    // backpressure toggling every cycle
    start(19'h20, 19'h2F, 1'b0, 200, 4);
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      mem_wr_full = k[0];
      #1;
      if (fifo_rd_en && mem_wr_full) bad++;
      if (!mem_wr_full && !fifo_empty && !fifo_rd_en) bad++;
      tick();
    end
    mem_wr_full = 1'b0;
    repeat (2) tick();
    chk("bp_viol", bad, 0);
    chk("bp_n", la.size(), 4);
    for (int k = 0; k < 4 && k < la.size(); k++) begin
      chk($sformatf("bp_addr%0d", k), la[k], 19'h20 + 19'(k));
      chk($sformatf("bp_data%0d", k), ld[k], word(200 + k));
    end
    chk("bp_wrc", wr_count, 11);

    // bad window holds IDLE, then a fixed high bound starts at low
    cfg_enable = 1'b0;
    tick();
    fq.delete();
    cfg_addr_low  = 19'd5;
    cfg_addr_high = 19'd4;
    cfg_wrap      = 1'b0;
    push(300, 2);
    cfg_enable = 1'b1;
    clr_log();
    tick();
    tick();
    #1;
    chk("ce_err", cfg_err, 1);
    chk("ce_busy", busy, 0);
    chk("ce_rd", fifo_rd_en, 0);
    chk("ce_stb", mem_ad_w_n, 1);
    cfg_addr_high = 19'd8;
    tick();
    chk("ce_clr", cfg_err, 0);
    chk("ce_run", busy, 1);
    repeat (4) tick();
    chk("ce_n", la.size(), 2);
    if (la.size() == 2) begin
      chk("ce_addr0", la[0], 5);
      chk("ce_addr1", la[1], 6);
    end
    chk("ce_wrc", wr_count, 13);

    // calibration gating at start and mid-run
    cfg_enable = 1'b0;
    tick();
    fq.delete();
    cal_done = 1'b0;
    cfg_addr_low  = 19'h40;
    cfg_addr_high = 19'h4F;
    push(400, 4);
    cfg_enable = 1'b1;
    repeat (3) tick();
    chk("cal_idle", busy, 0);
    chk("cal_nowr", mem_ad_w_n, 1);
    cal_done = 1'b1;
    tick();
    clr_log();
    tick();
    cal_done = 1'b0;
    #1;
    chk("cal_rd", fifo_rd_en, 0);
    repeat (3) tick();
    chk("cal_hold", busy, 1);
    chk("cal_fq", fq.size(), 3);
    cal_done = 1'b1;
    repeat (5) tick();
    chk("cal_n", la.size(), 4);
    for (int k = 0; k < 4 && k < la.size(); k++) begin
      chk($sformatf("cal_addr%0d", k), la[k], 19'h40 + 19'(k));
      chk($sformatf("cal_data%0d", k), ld[k], word(400 + k));
    end
    chk("cal_wrc", wr_count, 17);
    chk("cal_wrapc", wrap_count, 2);

    // sw_rst in the same cycle as an issue
    start(19'h60, 19'h6F, 1'b0, 500, 4);
    tick();
    chk("sr_fq0", fq.size(), 3);
    sw_rst = 1'b1;
    #1;
    chk("sr_rd", fifo_rd_en, 0);
    tick();
    sw_rst = 1'b0;
    chk("sr_busy", busy, 0);
    chk("sr_cnt", {wr_count, wrap_count}, 0);
    chk("sr_stb", mem_ad_w_n, 1);
    chk("sr_addr", mem_ad_wr, 0);
    chk("sr_data", {mem_dwh, mem_dwl}, 0);
    chk("sr_fq", fq.size(), 3);

    // asynchronous reset mid-stream
    tick();
    tick();
    chk("ar_pre", mem_ad_w_n, 0);
    #2 rst = 1'b1;
    #1;
    chk("ar_stb", {mem_ad_w_n, mem_d_w_n}, 2'b11);
    chk("ar_addr", mem_ad_wr, 0);
    chk("ar_data", {mem_dwh, mem_dwl}, 0);
    chk("ar_flags", {busy, done, cfg_err, fifo_rd_en}, 0);
    chk("ar_cnt", {wr_count, wrap_count}, 0);
    cfg_enable = 1'b0;
    #1 rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
